// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with load handshake,
// synchronous clear and auto-scan with per-line dwell.
module onehot_scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [SEL_W-1:0]        load_sel,
  input  logic                    load_mode,
  input  logic [DWELL_W-1:0]      load_dwell,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    active,
  output logic                    wrap
);

  localparam int N = 1 << SEL_W;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SCAN
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       out_q, out_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               wrap_q, wrap_d;
  logic               adv;

  assign adv = (state_q == SCAN) && (cnt_q == dwell_q);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    wrap_d  = wrap_q;
    if (en) begin
      wrap_d = 1'b0;
      if (clr) begin
        state_d = IDLE;
        out_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end else if (load_valid) begin
        state_d = load_mode ? SCAN : HOLD;
        out_d   = {{(N-1){1'b0}}, 1'b1} << load_sel;
        idx_d   = load_sel;
        cnt_d   = '0;
        dwell_d = load_dwell;
      end else if (state_q == SCAN) begin
        if (adv) begin
          // out is one-hot here, so a rotate tracks idx+1
          out_d  = {out_q[N-2:0], out_q[N-1]};
          idx_d  = idx_q + 1'b1;
          cnt_d  = '0;
          wrap_d = &idx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
    end
  end

  assign load_ready = en;
  assign out        = out_q;
  assign idx        = idx_q;
  assign active     = |out_q;
  assign wrap       = wrap_q & en;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboard bench for onehot_scan_decoder: the driver queues
// hand-derived expectations, the monitor checks each cycle.
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [2:0] load_sel = '0;
  logic       load_mode = 1'b0;
  logic [7:0] load_dwell = '0;
  logic [7:0] out;
  logic [2:0] idx;
  logic       active;
  logic       wrap;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] i;
    logic       w;
    logic       r;
  } exp_t;

  exp_t q[$];

  onehot_scan_decoder #(
    .SEL_W(3),
    .DWELL_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clr(clr),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_sel(load_sel),
    .load_mode(load_mode),
    .load_dwell(load_dwell),
    .out(out),
    .idx(idx),
    .active(active),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] a,
                     input logic [7:0] b);
    checks++;
    if (a !== b) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, b, $time);
    end
  endtask

  // one cycle of stimulus; eo/ew are the outputs after the next edge
  task automatic step(input logic r, input logic e, input logic c,
                      input logic lv, input logic [2:0] s,
                      input logic m, input logic [7:0] d,
                      input logic [7:0] eo, input logic ew);
    exp_t x;
    @(negedge clk);
    rst = r;
    en = e;
    clr = c;
    load_valid = lv;
    load_sel = s;
    load_mode = m;
    load_dwell = d;
    x.o = eo;
    x.i = '0;
    for (int k = 0; k < 8; k++)
      if (eo[k]) x.i = 3'(k);
    x.w = ew;
    x.r = e;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("out", out, x.o);
        chk("idx", {5'b0, idx}, {5'b0, x.i});
        chk("active", {7'b0, active}, {7'b0, x.o != 0});
        chk("wrap", {7'b0, wrap}, {7'b0, x.w});
        chk("ready", {7'b0, load_ready}, {7'b0, x.r});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int ln;
    // reset with a pending load
    repeat (2) step(1, 1, 0, 1, 3'd5, 0, 8'h11, 8'h00, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h00, 0);
    // direct decode, then hold with mode/dwell wiggling
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 1, 3'(i), 0, 8'd0, 8'h01 << i, 0);
    repeat (20) step(0, 1, 0, 0, 3'd0, 1, 8'd9, 8'h80, 0);
    // scan from 6, dwell 2, one full sweep plus
    step(0, 1, 0, 1, 3'd6, 1, 8'd2, 8'h40, 0);
    for (int t = 1; t <= 26; t++) begin
      ln = (6 + t / 3) % 8;
      step(0, 1, 0, 0, 3'd0, 0, 8'd7, 8'h01 << ln,
           (t % 3 == 0) && (ln == 0));
    end
    // dwell 0 scan from 0
    step(0, 1, 0, 1, 3'd0, 1, 8'd0, 8'h01, 0);
    for (int t = 1; t <= 17; t++) begin
      ln = t % 8;
      step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h01 << ln, ln == 0);
    end
    // freeze mid-line, dwell 3: line held 4+5 cycles
    step(0, 1, 0, 1, 3'd1, 1, 8'd3, 8'h02, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h02, 0);
    repeat (5) step(0, 0, 0, 1, 3'd7, 0, 8'd0, 8'h02, 0);
    repeat (2) step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h02, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h04, 0);
    // freeze right on a wrap: wrap must read 0
    step(0, 1, 0, 1, 3'd6, 1, 8'd0, 8'h40, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h80, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h01, 1);
    repeat (2) step(0, 0, 0, 0, 3'd0, 0, 8'd0, 8'h01, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h02, 0);
    // clr beats load mid-scan
    step(0, 1, 0, 1, 3'd3, 1, 8'd1, 8'h08, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h08, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h10, 0);
    step(0, 1, 1, 1, 3'd5, 0, 8'd0, 8'h00, 0);
    repeat (2) step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h00, 0);
    // load on the wrap cycle wins, then holds
    step(0, 1, 0, 1, 3'd6, 1, 8'd0, 8'h40, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h80, 0);
    step(0, 1, 0, 1, 3'd2, 0, 8'd0, 8'h04, 0);
    repeat (5) step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h04, 0);
    // clr while disabled is ignored
    step(0, 0, 1, 0, 3'd0, 0, 8'd0, 8'h04, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h04, 0);
    // reset mid-scan
    step(0, 1, 0, 1, 3'd4, 1, 8'd5, 8'h10, 0);
    step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h10, 0);
    step(1, 1, 0, 0, 3'd0, 0, 8'd0, 8'h00, 0);
    repeat (3) step(0, 1, 0, 0, 3'd0, 0, 8'd0, 8'h00, 0);
    @(posedge clk);
    #5;
    chk("drain", 8'(q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Parametrised, registered binary-to-one-hot decoder. It extends the team's fixed 3-to-8 combinational decoder with configurable select width, a valid/ready load handshake, a synchronous clear, and an auto-scan mode. In scan mode the active output walks through all 2^SEL_W lines, holding each one for a programmable dwell time. The block sits between control logic and downstream enable/strobe fan-out (row drivers, channel enables, display multiplexing) where glitch-free, registered one-hot selects are required.

## Interface
- SEL_W, 3: select width; output width N = 2^SEL_W (SEL_W ≥ 1).
- DWELL_W, 8: width of dwell-time field.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; 0 freezes all state.
- clr  in  1  synchronous clear to idle (all outputs low).
- load_valid  in  1  load request.
- load_ready  out  1  load can be accepted this cycle; equals en (combinational).
- load_sel  in  SEL_W  line index to activate.
- load_mode  in  1  0 = direct (hold), 1 = scan.
- load_dwell  in  DWELL_W  extra cycles each line is held in scan mode.
- out  out  N  registered one-hot output (or all zero when idle).
- idx  out  SEL_W  registered index of the active line.
- active  out  1  high when out is non-zero.
- wrap  out  1  one-cycle pulse when a scan advances from line N-1 to line 0.

## Operation
- States:
  - IDLE: out = 0, active = 0.
  - HOLD: direct mode; the line is held indefinitely.
  - SCAN: auto-advance mode.
- Load handshake: a load is accepted when load_valid & load_ready (i.e. load_valid & en) on a rising edge.
- On acceptance:
  - out ← 1 << load_sel, idx ← load_sel, active ← 1.
  - load_dwell is captured into an internal register, and the dwell counter is cleared.
  - The next state is HOLD if load_mode = 0, or SCAN if load_mode = 1.
- mode and dwell are sampled only at acceptance. Changing load_mode or load_dwell afterwards has no effect until the next accepted load.
- HOLD: out and idx stay constant until the next load, clr, or rst.
- SCAN:
  - The dwell counter increments each enabled cycle.
  - When the counter equals the captured dwell, the next cycle sets idx ← idx+1 (mod N), out ← 1 << new idx, and the counter resets to 0.
  - Each line is therefore active for exactly dwell+1 enabled cycles. dwell = 0 advances every cycle.
- wrap is asserted in the same cycle that out changes from line N-1 to line 0 due to a scan advance. It is never asserted on a load or in HOLD.
- en = 0:
  - State, out, idx, the dwell counter and wrap are frozen at their held values.
  - wrap is forced to 0 while en = 0.
  - load_ready = 0, so loads are not accepted.
- clr = 1 with en = 1: next state IDLE, out = 0, idx = 0, wrap = 0, dwell counter = 0.
- Priority per edge: rst > clr > accepted load > scan advance.
  - clr with load_valid: the load is ignored, even though load_ready = 1.
  - A load coinciding with a scan advance or a wrap: the load wins and wrap = 0.
- Arithmetic:
  - idx increments modulo N; natural SEL_W-bit wrap is required and no compare against N is needed.
  - The dwell counter is DWELL_W bits and never overflows, because it compares against the captured dwell ≤ 2^DWELL_W−1.
- out is a single registered vector and is always one-hot or zero; no output bit may glitch.

## Timing
- Reset (sync): out = 0, idx = 0, active = 0, wrap = 0, state IDLE, dwell counter = 0, captured dwell = 0. load_ready follows en while rst is high, but no load is accepted.
- Load latency: 1 cycle from the accepting edge to the new out value.
- Scan period: N·(dwell+1) enabled cycles per full sweep.
- wrap pulse: 1 enabled cycle wide, aligned with out[0] rising.
- clr latency: 1 cycle to out = 0.
- Reset mid-scan or mid-hold: the next cycle returns to the IDLE values above and the captured dwell is discarded.
- Freeze: deasserting en for k cycles stretches the current line's hold by exactly k cycles.

## Test plan
- Reset/idle: assert rst for 2 cycles while load_valid = 1 → out = 0x00, idx = 0, active = 0, wrap = 0 throughout, and no load is taken.
- Direct decode (SEL_W = 3): load sel = 0..7 in consecutive cycles with mode = 0 → out = 0x01, 0x02, …, 0x80, each one cycle after its load. Holding for 20 cycles after the last load keeps out = 0x80.
- Scan with dwell:
  - Load sel = 6, mode = 1, dwell = 2 → out = 0x40 for 3 cycles, then 0x80 for 3 cycles, then 0x01 with wrap = 1 for exactly 1 cycle.
  - Full sweep = 24 cycles.
- dwell = 0 scan: load sel = 0 → out advances every cycle. wrap pulses every 8 cycles, coincident with out = 0x01.
- Freeze: during a dwell = 3 scan, drop en for 5 cycles mid-line → out/idx unchanged and wrap = 0 while en = 0. That line stays active for 4+5 = 9 cycles, and load_valid during the freeze is ignored.
- Priority: mid-scan, assert clr and load_valid together → out = 0x00 next cycle. Next, assert a load (sel = 2, mode = 0) on the cycle a wrap would occur → out = 0x04, wrap = 0, and the line holds.
